// File: rtl/cmplx_sqrt_feeder.sv
// -----------------------------------------------------------------------------
// cmplx_sqrt_feeder
//
// Upstream sequencer for the complex square-root core. Samples arrive on a
// valid/ready port and are buffered in a small circular FIFO. The core is then
// launched one sample at a time with a single-cycle start pulse. The operands
// stay frozen while the core works. Each result is held on a valid/ready output
// port until the consumer takes it, so neither side has to handle the core's
// start/valid protocol directly.
//
// Optional feature (macro SQRT_FEEDER_TIMEOUT_EN):
//   When defined, a 16-bit counter limits the time spent waiting for the core.
//   When the counter reaches TIMEOUT, the sample is aborted and returned with
//   zero data and o_m_err = 1.
//   When undefined, no counter is built, WAIT lasts until the core answers, and
//   o_m_err is tied to 0.
//
// Parameters:
//   DEPTH    input FIFO depth (power of 2, >= 2)
//   N_ITER   iteration count driven on o_core_n
//   TIMEOUT  WAIT-state abort limit in cycles (only used with the macro)
//   DATA_W   sample / result width
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   i_s_valid / o_s_ready       input handshake; ready = FIFO not full
//   i_s_x, i_s_y                input sample (real / imaginary)
//   o_core_start                one-cycle launch pulse to the core
//   o_core_n                    constant iteration count
//   o_core_x, o_core_y          registered operands, held until the result
//   i_core_valid                core result strobe
//   i_core_re, i_core_im        core result
//   o_m_valid / i_m_ready       output handshake
//   o_m_re, o_m_im, o_m_err     registered result and abort flag
//   o_busy                      FSM active or FIFO not empty
//   o_fifo_count                current FIFO occupancy
// -----------------------------------------------------------------------------
module cmplx_sqrt_feeder #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [7:0]  N_ITER  = 8'd12,
    parameter logic [15:0] TIMEOUT = 16'd1023,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    input  logic signed [DATA_W-1:0] i_s_x,
    input  logic signed [DATA_W-1:0] i_s_y,
    output logic                     o_core_start,
    output logic [7:0]               o_core_n,
    output logic signed [DATA_W-1:0] o_core_x,
    output logic signed [DATA_W-1:0] o_core_y,
    input  logic                     i_core_valid,
    input  logic signed [DATA_W-1:0] i_core_re,
    input  logic signed [DATA_W-1:0] i_core_im,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic signed [DATA_W-1:0] o_m_re,
    output logic signed [DATA_W-1:0] o_m_im,
    output logic                     o_m_err,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic signed [DATA_W-1:0] r_mem_x [DEPTH];
    logic signed [DATA_W-1:0] r_mem_y [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;

    logic                     w_s_ready;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_capture;
    logic                     w_abort;
    logic                     w_release;
    logic                     w_to_hit;

    logic                     r_core_start;
    logic signed [DATA_W-1:0] r_core_x;
    logic signed [DATA_W-1:0] r_core_y;
    logic                     r_m_valid;
    logic signed [DATA_W-1:0] r_m_re;
    logic signed [DATA_W-1:0] r_m_im;

    // Ready depends only on the registered count. A pop in the same cycle
    // does not reopen a full FIFO, so there is no combinational path from
    // the FSM to the producer.
    assign w_s_ready = (r_count != FULL_CNT);
    assign w_push    = i_s_valid && w_s_ready;

    // ---------------- FIFO storage (data is not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= i_s_x;
            r_mem_y[r_wr_ptr] <= i_s_y;
        end
    end

    // ---------------- FIFO pointers and occupancy ----------------
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SQRT_FEEDER_TIMEOUT_EN
    // ---------------- WAIT-state abort counter ----------------
    logic [15:0] r_to_cnt;
    logic        r_m_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // The abort happens on the edge at which the counter would reach TIMEOUT.
    assign w_to_hit = ((r_to_cnt + 16'd1) == TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_err <= 1'b0;
        end else if (w_capture) begin
            r_m_err <= 1'b0;
        end else if (w_abort) begin
            r_m_err <= 1'b1;
        end
    end

    assign o_m_err = r_m_err;
`else
    // Without the abort counter, TIMEOUT has no effect.
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign w_to_hit         = 1'b0;
    assign o_m_err          = 1'b0;
`endif

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM next state / strobes ----------------
    // core_valid is looked at only in WAIT. Stray or late strobes in any
    // other state are ignored. When the result and the abort arrive on the
    // same edge, the result takes precedence.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_m_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- Registered core and result outputs ----------------
    // start is the pop strobe delayed by one register, so it is high exactly
    // while the FSM is in LAUNCH. The operands load only on a pop, so they
    // stay frozen through LAUNCH and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_start <= 1'b0;
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_m_valid    <= 1'b0;
            r_m_re       <= '0;
            r_m_im       <= '0;
        end else begin
            r_core_start <= w_pop;
            if (w_pop) begin
                r_core_x <= r_mem_x[r_rd_ptr];
                r_core_y <= r_mem_y[r_rd_ptr];
            end
            if (w_capture) begin
                r_m_re <= i_core_re;
                r_m_im <= i_core_im;
            end else if (w_abort) begin
                r_m_re <= '0;
                r_m_im <= '0;
            end
            if (w_capture || w_abort) begin
                r_m_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_core_start = r_core_start;
    assign o_core_n     = N_ITER;
    assign o_core_x     = r_core_x;
    assign o_core_y     = r_core_y;
    assign o_m_valid    = r_m_valid;
    assign o_m_re       = r_m_re;
    assign o_m_im       = r_m_im;
    assign o_busy       = (r_state != S_IDLE) || (r_count != '0);
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_cmplx_sqrt_feeder.sv
// -----------------------------------------------------------------------------
// tb_cmplx_sqrt_feeder
//
// Directed bench for cmplx_sqrt_feeder. A behavioural core stub answers each
// launch after a programmable latency. It returns either fixed data or
// (x + 100, y - 50). A table of single-sample vectors is followed by
// hand-written sequences for the full FIFO, backpressure, stray strobes, reset
// mid-WAIT and, when SQRT_FEEDER_TIMEOUT_EN is defined, the abort path.
// -----------------------------------------------------------------------------
module tb_cmplx_sqrt_feeder;

`ifdef SQRT_FEEDER_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd16;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd1023;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               o_s_ready;
    logic signed [15:0] s_x, s_y;
    logic               o_core_start;
    logic [7:0]         o_core_n;
    logic signed [15:0] o_core_x, o_core_y;
    logic               core_valid;
    logic signed [15:0] core_re, core_im;
    logic               o_m_valid;
    logic               m_ready;
    logic signed [15:0] o_m_re, o_m_im;
    logic               o_m_err;
    logic               o_busy;
    logic [2:0]         o_fifo_count;

    cmplx_sqrt_feeder #(
        .DEPTH   (4),
        .N_ITER  (8'd12),
        .TIMEOUT (TB_TIMEOUT),
        .DATA_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_s_valid    (s_valid),
        .o_s_ready    (o_s_ready),
        .i_s_x        (s_x),
        .i_s_y        (s_y),
        .o_core_start (o_core_start),
        .o_core_n     (o_core_n),
        .o_core_x     (o_core_x),
        .o_core_y     (o_core_y),
        .i_core_valid (core_valid),
        .i_core_re    (core_re),
        .i_core_im    (core_im),
        .o_m_valid    (o_m_valid),
        .i_m_ready    (m_ready),
        .o_m_re       (o_m_re),
        .o_m_im       (o_m_im),
        .o_m_err      (o_m_err),
        .o_busy       (o_busy),
        .o_fifo_count (o_fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               err;
    } res_t;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] resp_re;
        logic signed [15:0] resp_im;
        int                 lat;
        logic signed [15:0] exp_re;
        logic signed [15:0] exp_im;
        int                 exp_lat;
    } vec_t;

    res_t res_q[$];
    res_t exp_q[$];

    int total;
    int bad;
    int cyc;
    int n_starts;
    int start_edge;
    int mv_cyc;
    int acc_cnt;

    int                 stub_cd;
    int                 stub_lat;
    bit                 stub_en;
    bit                 fixed_mode;
    logic signed [15:0] fix_re, fix_im;
    logic signed [15:0] launch_x, launch_y;
    logic signed [15:0] ans_x, ans_y;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Advances one clock. Handshakes are judged on the values that are stable
    // before the rising edge. The core stub acts on the falling edge.
    task automatic step();
        logic hs_m;
        logic hs_s;
        res_t r;
        hs_m  = o_m_valid && m_ready;
        hs_s  = s_valid && o_s_ready;
        r.re  = o_m_re;
        r.im  = o_m_im;
        r.err = o_m_err;
        @(negedge clk);
        cyc++;
        if (hs_m) res_q.push_back(r);
        if (hs_s) acc_cnt++;
        if (o_m_valid && mv_cyc < 0) mv_cyc = cyc;
        core_valid = 1'b0;
        if (stub_cd > 0) begin
            stub_cd--;
            if (stub_cd == 0) begin
                core_valid = 1'b1;
                ans_x      = o_core_x;
                ans_y      = o_core_y;
                core_re    = fixed_mode ? fix_re : launch_x + 16'sd100;
                core_im    = fixed_mode ? fix_im : launch_y - 16'sd50;
            end
        end
        if (o_core_start) begin
            n_starts++;
            start_edge = cyc + 1;
            launch_x   = o_core_x;
            launch_y   = o_core_y;
            if (stub_en) stub_cd = stub_lat;
        end
    endtask

    task automatic push(input logic signed [15:0] x, input logic signed [15:0] y,
                        input int bound, output bit ok);
        int a0;
        a0      = acc_cnt;
        s_valid = 1'b1;
        s_x     = x;
        s_y     = y;
        ok      = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            ok = (acc_cnt != a0);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input int bound, output bit ok);
        ok = (res_q.size() >= n);
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            ok = (res_q.size() >= n);
        end
    endtask

    task automatic wait_mv(input int bound, output bit ok);
        ok = o_m_valid;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            ok = o_m_valid;
        end
    endtask

    initial begin
        vec_t               vt[4];
        logic signed [15:0] fx[6];
        logic signed [15:0] fy[6];
        res_t               r;
        res_t               e;
        bit                 ok;
        bit                 stable;
        int                 k;
        int                 h;
        int                 n0;
        int                 a0;
        int                 rq0;
        logic signed [15:0] hre, him;

        vt[0] = '{-16'sd3,     16'sd7,      16'sh7fff, 16'sh8000, 1,  16'sh7fff, 16'sh8000, 3};
        vt[1] = '{16'sd32767,  -16'sd32768, 16'shffff, 16'sh0001, 3,  16'shffff, 16'sh0001, 5};
        vt[2] = '{16'sd0,      16'sd0,      16'sh00ff, 16'shff00, 10, 16'sh00ff, 16'shff00, 12};
        vt[3] = '{-16'sd1,     -16'sd1,     16'sh5a5a, 16'sha5a5, 2,  16'sh5a5a, 16'sha5a5, 4};

        total = 0;  bad = 0;  cyc = 0;  n_starts = 0;  start_edge = 0;
        mv_cyc = -1;  acc_cnt = 0;  stub_cd = 0;  stub_lat = 5;  stub_en = 1'b1;
        fixed_mode = 1'b0;  fix_re = '0;  fix_im = '0;
        launch_x = '0;  launch_y = '0;  ans_x = '0;  ans_y = '0;
        rst = 1'b1;  s_valid = 1'b0;  s_x = '0;  s_y = '0;
        core_valid = 1'b0;  core_re = '0;  core_im = '0;  m_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_s_ready",    16'(o_s_ready),    16'd1);
        chk("rst_core_start", 16'(o_core_start), 16'd0);
        chk("rst_core_x",     o_core_x,          16'd0);
        chk("rst_m_valid",    16'(o_m_valid),    16'd0);
        chk("rst_m_re",       o_m_re,            16'd0);
        chk("rst_m_err",      16'(o_m_err),      16'd0);
        chk("rst_busy",       16'(o_busy),       16'd0);
        chk("rst_fifo_count", 16'(o_fifo_count), 16'd0);
        chk("core_n",         16'(o_core_n),     16'd12);
        rst = 1'b0;
        step();

        // ---------------- single sample ----------------
        fixed_mode = 1'b1;  fix_re = 16'sh1234;  fix_im = 16'sh0567;  stub_lat = 20;
        m_ready = 1'b1;  n0 = n_starts;  mv_cyc = -1;  res_q.delete();
        push(16'sd3, 16'sd4, 10, ok);
        chk("single_push", 16'(ok), 16'd1);
        k = cyc;
        wait_res(1, 100, ok);
        chk("single_result_seen", 16'(ok), 16'd1);
        chk("single_start_count", 16'(n_starts - n0),   16'd1);
        chk("single_start_edge",  16'(start_edge - k),  16'd2);
        chk("single_held_x",      ans_x,                16'd3);
        chk("single_held_y",      ans_y,                16'd4);
        chk("single_mvalid_lat",  16'(mv_cyc - k),      16'd22);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("single_re",  r.re,       16'h1234);
            chk("single_im",  r.im,       16'h0567);
            chk("single_err", 16'(r.err), 16'd0);
        end

        // ---------------- table of single-sample vectors ----------------
        for (int v = 0; v < 4; v++) begin
            fix_re = vt[v].resp_re;  fix_im = vt[v].resp_im;  stub_lat = vt[v].lat;
            n0 = n_starts;  mv_cyc = -1;  res_q.delete();
            push(vt[v].x, vt[v].y, 10, ok);
            k = cyc;
            wait_res(1, 100, ok);
            chk($sformatf("vec%0d_result_seen", v), 16'(ok), 16'd1);
            chk($sformatf("vec%0d_held_x", v), ans_x, vt[v].x);
            chk($sformatf("vec%0d_held_y", v), ans_y, vt[v].y);
            chk($sformatf("vec%0d_lat", v), 16'(mv_cyc - k), 16'(vt[v].exp_lat));
            chk($sformatf("vec%0d_starts", v), 16'(n_starts - n0), 16'd1);
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk($sformatf("vec%0d_re", v),  r.re,       vt[v].exp_re);
                chk($sformatf("vec%0d_im", v),  r.im,       vt[v].exp_im);
                chk($sformatf("vec%0d_err", v), 16'(r.err), 16'd0);
            end
        end

        // ---------------- full FIFO with stalled consumer ----------------
        fixed_mode = 1'b0;  stub_lat = 5;  m_ready = 1'b0;
        res_q.delete();  exp_q.delete();  n0 = n_starts;
        for (int i = 0; i < 6; i++) begin
            fx[i] = 16'(100 * i - 250);
            fy[i] = 16'(7 - 1000 * i);
            e.re  = fx[i] + 16'sd100;
            e.im  = fy[i] - 16'sd50;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            push(fx[i], fy[i], 10, ok);
            chk($sformatf("full_push%0d", i), 16'(ok), 16'd1);
        end
        chk("full_count_after5", 16'(o_fifo_count), 16'd4);
        chk("full_s_ready_low",  16'(o_s_ready),    16'd0);
        a0 = acc_cnt;
        s_valid = 1'b1;  s_x = fx[5];  s_y = fy[5];
        for (int i = 0; i < 20; i++) step();
        chk("full_sixth_blocked", 16'(acc_cnt - a0),    16'd0);
        chk("full_count_stalled", 16'(o_fifo_count),    16'd4);
        chk("full_one_launch",    16'(n_starts - n0),   16'd1);
        chk("full_hold_valid",    16'(o_m_valid),       16'd1);
        m_ready = 1'b1;
        push(fx[5], fy[5], 60, ok);
        chk("full_sixth_push", 16'(ok), 16'd1);
        wait_res(6, 400, ok);
        chk("full_all_results", 16'(ok), 16'd1);
        for (int i = 0; i < 6; i++) begin
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk($sformatf("full_re%0d", i), r.re, exp_q[i].re);
                chk($sformatf("full_im%0d", i), r.im, exp_q[i].im);
            end
        end
        step();
        step();
        chk("full_no_extra",   16'(res_q.size()),   16'd0);
        chk("full_starts",     16'(n_starts - n0),  16'd6);
        chk("full_count_zero", 16'(o_fifo_count),   16'd0);
        chk("full_busy_zero",  16'(o_busy),         16'd0);

        // ---------------- backpressure and stray valid in HOLD ----------------
        m_ready = 1'b0;  res_q.delete();  n0 = n_starts;
        push(16'sd1234, -16'sd4321, 10, ok);
        push(-16'sd5, 16'sd6, 10, ok);
        wait_mv(50, ok);
        chk("bp_mvalid_seen", 16'(ok), 16'd1);
        hre = o_m_re;
        him = o_m_im;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                core_valid = 1'b1;
                core_re    = 16'sh7777;
                core_im    = 16'sh6666;
            end
            step();
            if (!o_m_valid || o_m_re !== hre || o_m_im !== him || o_m_err !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable",  16'(stable),         16'd1);
        chk("bp_starts",  16'(n_starts - n0),  16'd1);
        chk("bp_re",      hre,                 16'sd1334);
        chk("bp_im",      him,                 -16'sd4371);
        m_ready = 1'b1;
        step();
        h = cyc;
        m_ready = 1'b0;
        chk("bp_accepted", 16'(res_q.size()), 16'd1);
        for (int i = 0; i < 10 && (n_starts - n0) < 2; i++) step();
        chk("bp_next_start", 16'(start_edge - h), 16'd2);
        m_ready = 1'b1;
        wait_res(2, 100, ok);
        chk("bp_second_seen", 16'(ok), 16'd1);
        if (res_q.size() == 2) begin
            r = res_q.pop_back();
            chk("bp_second_re", r.re, 16'sd95);
            chk("bp_second_im", r.im, -16'sd44);
        end

        // ---------------- stray valid in IDLE ----------------
        for (int i = 0; i < 3; i++) step();
        n0 = n_starts;  rq0 = res_q.size();
        core_valid = 1'b1;  core_re = 16'sh1111;  core_im = 16'sh2222;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("idle_stray_mvalid", 16'(o_m_valid),        16'd0);
        chk("idle_stray_busy",   16'(o_busy),           16'd0);
        chk("idle_stray_starts", 16'(n_starts - n0),    16'd0);
        chk("idle_stray_res",    16'(res_q.size() - rq0), 16'd0);
        chk("idle_stray_m_re",   o_m_re,                16'sd95);

        // ---------------- reset mid-WAIT with samples queued ----------------
        stub_lat = 30;  m_ready = 1'b1;  res_q.delete();  n0 = n_starts;
        push(16'sd21, 16'sd22, 10, ok);
        push(16'sd23, 16'sd24, 10, ok);
        push(16'sd25, 16'sd26, 10, ok);
        push(16'sd27, 16'sd28, 10, ok);
        for (int i = 0; i < 5; i++) step();
        chk("mid_count_before", 16'(o_fifo_count), 16'd3);
        chk("mid_core_x_before", o_core_x, 16'sd21);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count",   16'(o_fifo_count), 16'd0);
        chk("mid_rst_s_ready", 16'(o_s_ready),    16'd1);
        chk("mid_rst_core_x",  o_core_x,          16'd0);
        chk("mid_rst_core_y",  o_core_y,          16'd0);
        chk("mid_rst_m_re",    o_m_re,            16'd0);
        chk("mid_rst_m_valid", 16'(o_m_valid),    16'd0);
        chk("mid_rst_busy",    16'(o_busy),       16'd0);
        chk("mid_rst_start",   16'(o_core_start), 16'd0);
        stub_cd = 0;
        core_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("post_rst_no_result", 16'(res_q.size()),  16'd0);
        chk("post_rst_starts",    16'(n_starts - n0), 16'd1);
        chk("post_rst_busy",      16'(o_busy),        16'd0);
        stub_lat = 5;
        push(16'sd500, -16'sd500, 10, ok);
        wait_res(1, 100, ok);
        chk("post_rst_new_seen", 16'(ok), 16'd1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("post_rst_new_re", r.re, 16'sd600);
            chk("post_rst_new_im", r.im, -16'sd550);
        end

`ifdef SQRT_FEEDER_TIMEOUT_EN
        // ---------------- timeout abort, late valid, next launch ----------------
        stub_en = 1'b0;  m_ready = 1'b0;  res_q.delete();  n0 = n_starts;  mv_cyc = -1;
        push(16'sd11, 16'sd22, 10, ok);
        push(16'sd33, 16'sd44, 10, ok);
        wait_mv(100, ok);
        chk("to_mvalid_seen", 16'(ok),                   16'd1);
        chk("to_latency",     16'(mv_cyc - start_edge),  16'd16);
        chk("to_err",         16'(o_m_err),              16'd1);
        chk("to_re_zero",     o_m_re,                    16'd0);
        chk("to_im_zero",     o_m_im,                    16'd0);
        core_valid = 1'b1;  core_re = 16'sh2222;  core_im = 16'sh3333;
        step();
        for (int i = 0; i < 3; i++) step();
        chk("to_late_ignored_re",  o_m_re,           16'd0);
        chk("to_late_ignored_err", 16'(o_m_err),     16'd1);
        chk("to_late_starts",      16'(n_starts - n0), 16'd1);
        stub_en = 1'b1;  stub_lat = 4;  m_ready = 1'b1;
        wait_res(2, 100, ok);
        chk("to_both_results", 16'(ok), 16'd1);
        if (res_q.size() == 2) begin
            r = res_q.pop_front();
            chk("to_first_err",  16'(r.err), 16'd1);
            r = res_q.pop_front();
            chk("to_second_err", 16'(r.err), 16'd0);
            chk("to_second_re",  r.re,       16'sd133);
            chk("to_second_im",  r.im,       -16'sd6);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmplx_sqrt_feeder.md
# cmplx_sqrt_feeder

Upstream sequencer for the complex square-root core. Accepts a stream of signed 16-bit complex samples over a valid/ready handshake and buffers them in a small FIFO. Launches the core one sample at a time with a single-cycle `start` pulse, holding operands stable, and waits for `cmplx_sqrt_valid`. Returns each result on a valid/ready output port, so upstream producers and downstream consumers never handle the core's start/valid protocol directly.

## Interface
- `DEPTH`, 4: input FIFO depth; power of 2, ≥2.
- `N_ITER`, 8'd12: iteration count driven on `core_N`.
- `TIMEOUT`, 16'd1023: maximum cycles spent in WAIT before abort (only with `SQRT_FEEDER_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: FIFO can accept; equals `count != DEPTH`.
- `s_x`, `s_y` in 16 signed: real and imaginary parts of the input sample.
- `core_start` out 1: one-cycle launch pulse to the core.
- `core_N` out 8: constant `N_ITER`.
- `core_x`, `core_y` out 16 signed: registered operands to the core.
- `core_valid` in 1: core result valid (`cmplx_sqrt_valid`).
- `core_re`, `core_im` in 16 signed: core result.
- `m_valid` out 1: result available.
- `m_ready` in 1: consumer accepts the result.
- `m_re`, `m_im` out 16 signed: registered result.
- `m_err` out 1: result was aborted by timeout; qualified by `m_valid`.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO:** registered circular buffer with wrap-around read/write pointers.
  - Push when `s_valid && s_ready`.
  - Pop only by the FSM when leaving IDLE.
  - Push and pop in the same cycle: count unchanged.
  - When full, `s_ready` is 0, including during a same-cycle pop; no combinational ready path.
- **FSM states:** IDLE, LAUNCH, WAIT, HOLD.
- **IDLE:**
  - If `count != 0`: pop head, register it into `core_x`/`core_y`, go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH:** `core_start` = 1 for exactly this one cycle, then go to WAIT; clear the timeout counter.
- **WAIT:**
  - On `core_valid`: capture `core_re`/`core_im` into `m_re`/`m_im`, set `m_err` = 0, go to HOLD.
  - `core_x`/`core_y` stay frozen from the IDLE pop until WAIT exits.
- **HOLD:** `m_valid` = 1, with `m_re`/`m_im`/`m_err` stable. On `m_ready`, go to IDLE.
- **Backpressure:** `m_valid` may stay asserted indefinitely; the core is not relaunched while in HOLD.
- **Stray `core_valid`:** ignored in IDLE, LAUNCH and HOLD.
- **Reset values** (`rst` high, any time, including mid-WAIT):
  - State IDLE; FIFO emptied, pointers 0, `fifo_count` 0.
  - `core_start`, `core_x`, `core_y`, `m_valid`, `m_re`, `m_im`, `m_err`, `busy` all 0.
  - `s_ready` 1.
  - Any in-flight result is discarded. The core shares `rst`.

## Timing
- **Push to launch:** sample pushed at edge k → popped at edge k+1 (FSM in IDLE) → `core_start` high in the cycle after edge k+1 → WAIT after edge k+2.
- **Result capture:** `core_valid` sampled high at edge j → `m_valid` high after edge j.
- **Output handshake:** `m_valid && m_ready` at edge h → IDLE after h → next pop at edge h+1 → next `core_start` after h+1.
- **Overhead:** 3 cycles per sample on top of core latency when the consumer is always ready.
- **Output registration:** all outputs registered except `s_ready`, `busy` and `fifo_count`, which are decoded from registers only.

## Configuration
- Macro: `SQRT_FEEDER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter increments each cycle in WAIT.
  - When it reaches `TIMEOUT` without `core_valid`, go to HOLD with `m_re` = `m_im` = 0 and `m_err` = 1.
  - `core_valid` and the timeout on the same edge: `core_valid` wins, `m_err` = 0.
  - The late `core_valid` of an aborted sample arrives outside WAIT and is ignored.
- **Undefined:**
  - No counter is built; WAIT waits indefinitely.
  - `m_err` is tied to 0.

## Test plan
- **Single sample:** reset, push x=16'sd3, y=16'sd4. A core stub answers re=16'h1234, im=16'h0567 after 20 cycles → exactly one `core_start` pulse, 2 cycles after the push edge. `core_x`/`core_y` = 3/4 held through WAIT. `m_valid` with 1234/0567, `m_err` = 0.
- **Full FIFO:** hold `m_ready` = 0 and push 6 samples back-to-back → `s_ready` drops after `DEPTH` = 4 are buffered plus 1 in flight. Outputs appear later in push order, none lost or duplicated, `fifo_count` consistent.
- **Backpressure:** keep `m_ready` = 0 for 50 cycles in HOLD → `m_valid` and data stable. No `core_start` until the cycle after acceptance.
- **Stray valid:** assert `core_valid` while in IDLE and in HOLD → no state change, no data change.
- **Reset mid-operation:** assert `rst` mid-WAIT with 3 samples queued → all outputs go to their reset values immediately. After release, no result is emitted until a new push.
- **Timeout (`SQRT_FEEDER_TIMEOUT_EN`, `TIMEOUT` = 16):** stub never answers → `m_valid` with `m_err` = 1 and zero data, 16 cycles after entering WAIT. Then a late `core_valid` is ignored and the next queued sample launches.
